// File: rtl/mu0_mem_router.sv
// mu0_mem_router
// ---------------------------------------------------------------------------
// Address-decoding router between the MU0 datapath memory port and two
// responders: main RAM (Address < IO_BASE) and the memory-mapped I/O block
// (Address >= IO_BASE). One transaction is in flight at a time.
//
// Handshake: a select (RamSel/IoSel) is a level request. It rises the cycle
// after the processor request is sampled in IDLE and stays high until the
// first rising edge at which the matching Ack is high; read data is taken
// from that target on that same edge. If TIMEOUT+1 wait cycles pass without
// an Ack, the select is dropped and the transaction ends with Done and Err.
//
// Ports
//   Clk, Reset       clock (rising edge), asynchronous active-low reset
//   Address, WrData  processor request address / write data
//   Rd, Wr           processor request strobes, sampled only in IDLE
//   RdData           read result, held until the next successful read
//   Busy, Done, Err  status: in flight, one-cycle completion, error pulse
//   MemAddr, MemWrData, MemWr   latched request, shared by both targets
//   RamSel, IoSel    level requests to RAM / I/O
//   RamRdData, RamAck, IoRdData, IoAck   responder returns
//   DbgState         current FSM state (0 IDLE, 1 WAIT, 2 DONE)
// ---------------------------------------------------------------------------
module mu0_mem_router #(
   parameter int                ADDR_W  = 12,
   parameter int                DATA_W  = 16,
   parameter logic [ADDR_W-1:0] IO_BASE = 12'hF00,
   parameter int                TIMEOUT = 15
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic [ADDR_W-1:0] Address,
   input  logic [DATA_W-1:0] WrData,
   input  logic              Rd,
   input  logic              Wr,
   output logic [DATA_W-1:0] RdData,
   output logic              Busy,
   output logic              Done,
   output logic              Err,
   output logic [ADDR_W-1:0] MemAddr,
   output logic [DATA_W-1:0] MemWrData,
   output logic              MemWr,
   output logic              RamSel,
   output logic              IoSel,
   input  logic [DATA_W-1:0] RamRdData,
   input  logic              RamAck,
   input  logic [DATA_W-1:0] IoRdData,
   input  logic              IoAck,
   output logic [1:0]        DbgState
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_WAIT = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   localparam logic [7:0] TMO = 8'(TIMEOUT);

   logic [1:0]        state_q, state_d;
   logic [7:0]        cnt_q, cnt_d;
   logic [DATA_W-1:0] rd_data_q, rd_data_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wr_data_q, wr_data_d;
   logic              wr_q, wr_d;
   logic              ram_sel_q, ram_sel_d;
   logic              io_sel_q, io_sel_d;
   logic              err_q, err_d;
   logic              ack_hit;

   // Only the Ack of the currently selected target counts; exactly one
   // select is high throughout WAIT.
   assign ack_hit = (ram_sel_q & RamAck) | (io_sel_q & IoAck);

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      rd_data_d = rd_data_q;
      addr_d    = addr_q;
      wr_data_d = wr_data_q;
      wr_d      = wr_q;
      ram_sel_d = ram_sel_q;
      io_sel_d  = io_sel_q;
      err_d     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (Rd && Wr) begin
               err_d = 1'b1;
            end else if (Rd || Wr) begin
               addr_d    = Address;
               wr_data_d = WrData;
               wr_d      = Wr;
               cnt_d     = 8'd0;
               if (Address >= IO_BASE) io_sel_d  = 1'b1;
               else                    ram_sel_d = 1'b1;
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            // Ack is checked before the timeout so a response on the
            // final permitted cycle still completes successfully.
            if (ack_hit) begin
               if (!wr_q) rd_data_d = io_sel_q ? IoRdData : RamRdData;
               ram_sel_d = 1'b0;
               io_sel_d  = 1'b0;
               state_d   = ST_DONE;
            end else if (cnt_q == TMO) begin
               ram_sel_d = 1'b0;
               io_sel_d  = 1'b0;
               err_d     = 1'b1;
               state_d   = ST_DONE;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            ram_sel_d = 1'b0;
            io_sel_d  = 1'b0;
            state_d   = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state_q   <= ST_IDLE;
         cnt_q     <= 8'd0;
         rd_data_q <= '0;
         addr_q    <= '0;
         wr_data_q <= '0;
         wr_q      <= 1'b0;
         ram_sel_q <= 1'b0;
         io_sel_q  <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         rd_data_q <= rd_data_d;
         addr_q    <= addr_d;
         wr_data_q <= wr_data_d;
         wr_q      <= wr_d;
         ram_sel_q <= ram_sel_d;
         io_sel_q  <= io_sel_d;
         err_q     <= err_d;
      end
   end

   assign RdData    = rd_data_q;
   assign MemAddr   = addr_q;
   assign MemWrData = wr_data_q;
   assign MemWr     = wr_q;
   assign RamSel    = ram_sel_q;
   assign IoSel     = io_sel_q;
   assign Err       = err_q;
   assign Busy      = (state_q != ST_IDLE);
   assign Done      = (state_q == ST_DONE);
   assign DbgState  = state_q;

endmodule

// File: tb/tb_mu0_mem_router.sv
// Bench for mu0_mem_router: directed cases for the decode boundary, timeout
// and illegal-request paths, then randomized transactions. Expected results
// are queued at issue time and checked by an independent monitor.
module tb_mu0_mem_router;

   localparam int TMO = 15;

   logic        Clk = 1'b0;
   logic        Reset;
   logic [11:0] Address;
   logic [15:0] WrData;
   logic        Rd, Wr;
   logic [15:0] RdData;
   logic        Busy, Done, Err;
   logic [11:0] MemAddr;
   logic [15:0] MemWrData;
   logic        MemWr, RamSel, IoSel;
   logic [15:0] RamRdData, IoRdData;
   logic        RamAck, IoAck;
   logic [1:0]  DbgState;

   mu0_mem_router #(.ADDR_W(12), .DATA_W(16), .IO_BASE(12'hF00), .TIMEOUT(TMO)) dut (
      .Clk(Clk), .Reset(Reset), .Address(Address), .WrData(WrData),
      .Rd(Rd), .Wr(Wr), .RdData(RdData), .Busy(Busy), .Done(Done), .Err(Err),
      .MemAddr(MemAddr), .MemWrData(MemWrData), .MemWr(MemWr),
      .RamSel(RamSel), .IoSel(IoSel), .RamRdData(RamRdData), .RamAck(RamAck),
      .IoRdData(IoRdData), .IoAck(IoAck), .DbgState(DbgState)
   );

   // ---------------- clock / cycle counter ----------------
   always #5 Clk = ~Clk;

   int cyc = 0;
   always @(posedge Clk) cyc <= cyc + 1;

   // ---------------- scoreboard ----------------
   // entry: [25] timeout, [24] illegal request, [23:16] latency, [15:0] RdData
   logic [25:0] exp_q[$];
   int          issue_q[$];
   int          compared   = 0;
   int          mismatched = 0;
   logic [15:0] model_rd   = 16'h0000;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- monitor ----------------
   logic [25:0] mon_e;
   int          mon_ic;
   always @(negedge Clk) begin
      if (Reset === 1'b1) begin
         check("sel_exclusive", {31'd0, RamSel & IoSel}, 32'd0);
         if (Done || Err) begin
            if (exp_q.size() == 0) begin
               compared++;
               mismatched++;
               $display("FAIL unexpected_event: Done=%b Err=%b with nothing outstanding", Done, Err);
            end else begin
               mon_e  = exp_q.pop_front();
               mon_ic = issue_q.pop_front();
               check("done_err", {30'd0, Done, Err},
                     mon_e[24] ? 32'd1 : {30'd0, 1'b1, mon_e[25]});
               if (!mon_e[24]) begin
                  check("rd_data", {16'd0, RdData}, {16'd0, mon_e[15:0]});
                  check("latency", cyc - mon_ic, {24'd0, mon_e[23:16]});
               end
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   // delay: cycles of Sel before Ack (Ack sampled on the edge ending WAIT
   // cycle 'delay'); anything above TMO or negative means no Ack at all.
   task automatic issue(input logic [11:0] addr, input bit wr, input logic [15:0] wd,
                        input int delay, input logic [15:0] resp, input bit rd_poke);
      bit to_io, tmo;
      int sel_cyc, lat;
      to_io   = (addr >= 12'hF00);
      tmo     = (delay < 0) || (delay > TMO);
      sel_cyc = tmo ? TMO + 1 : delay + 1;
      lat     = tmo ? TMO + 2 : delay + 2;
      if (!wr && !tmo) model_rd = resp;
      @(negedge Clk);
      Address = addr; WrData = wd; Rd = !wr; Wr = wr;
      exp_q.push_back({tmo, 1'b0, 8'(lat), model_rd});
      issue_q.push_back(cyc);
      @(posedge Clk);
      #1;
      Rd = 1'b0; Wr = 1'b0; Address = 12'($urandom); WrData = 16'($urandom);
      for (int k = 0; k < sel_cyc; k++) begin
         @(negedge Clk);
         check("ram_sel", {31'd0, RamSel}, {31'd0, !to_io});
         check("io_sel", {31'd0, IoSel}, {31'd0, to_io});
         check("busy_wait", {31'd0, Busy}, 32'd1);
         check("mem_addr", {20'd0, MemAddr}, {20'd0, addr});
         check("mem_wr", {31'd0, MemWr}, {31'd0, wr});
         if (wr) check("mem_wrdata", {16'd0, MemWrData}, {16'd0, wd});
         Rd = rd_poke && (k == 0);
         if (to_io) begin
            IoAck     = !tmo && (k == delay);
            IoRdData  = (!tmo && k == delay) ? resp : 16'($urandom);
            RamAck    = 1'($urandom);
            RamRdData = 16'($urandom);
         end else begin
            RamAck    = !tmo && (k == delay);
            RamRdData = (!tmo && k == delay) ? resp : 16'($urandom);
            IoAck     = 1'($urandom);
            IoRdData  = 16'($urandom);
         end
      end
      @(negedge Clk);
      RamAck = 1'b0; IoAck = 1'b0; Rd = 1'b0;
      check("busy_done", {31'd0, Busy}, 32'd1);
      check("sels_done", {30'd0, RamSel, IoSel}, 32'd0);
   endtask

   task automatic illegal();
      @(negedge Clk);
      Rd = 1'b1; Wr = 1'b1; Address = 12'($urandom);
      exp_q.push_back({2'b01, 24'h0});
      issue_q.push_back(cyc);
      @(posedge Clk);
      #1;
      Rd = 1'b0; Wr = 1'b0;
      @(negedge Clk);
      check("illegal_busy", {31'd0, Busy}, 32'd0);
      check("illegal_sels", {30'd0, RamSel, IoSel}, 32'd0);
      @(negedge Clk);
      check("illegal_err_len", {31'd0, Err}, 32'd0);
   endtask

   function automatic logic [11:0] pick_addr();
      case ($urandom_range(0, 3))
         0:       return ($urandom_range(0, 1) == 0) ? 12'hEFF : 12'hF00;
         1:       return 12'($urandom);
         2:       return 12'($urandom_range(0, 12'hEFF));
         default: return 12'($urandom_range(12'hF00, 12'hFFF));
      endcase
   endfunction

   // ---------------- main sequence ----------------
   initial begin
      Reset = 1'b0; Rd = 1'b0; Wr = 1'b0; Address = '0; WrData = '0;
      RamAck = 1'b0; IoAck = 1'b0; RamRdData = '0; IoRdData = '0;
      repeat (2) @(negedge Clk);
      Reset = 1'b1;
      @(negedge Clk);
      check("rst_rddata", {16'd0, RdData}, 32'd0);
      check("rst_status", {29'd0, Busy, Done, Err}, 32'd0);
      check("rst_sels", {29'd0, RamSel, IoSel, MemWr}, 32'd0);
      check("rst_memaddr", {20'd0, MemAddr}, 32'd0);
      check("rst_state", {30'd0, DbgState}, 32'd0);

      // directed cases
      issue(12'h010, 1'b0, 16'h0000, 0, 16'hBEEF, 1'b0);
      issue(12'hF00, 1'b1, 16'h1234, 3, 16'h5555, 1'b0);
      issue(12'hEFF, 1'b0, 16'h0000, 2, 16'h1111, 1'b0);
      issue(12'hFFF, 1'b0, 16'h0000, 1, 16'h2222, 1'b0);
      issue(12'hF05, 1'b0, 16'h0000, -1, 16'h9999, 1'b0);
      issue(12'h005, 1'b0, 16'h0000, TMO, 16'h3333, 1'b0);
      issue(12'h006, 1'b0, 16'h0000, TMO + 1, 16'h4444, 1'b0);
      illegal();
      issue(12'h100, 1'b0, 16'h0000, 2, 16'h6666, 1'b1);

      // asynchronous reset in the middle of a RAM wait
      @(negedge Clk);
      Address = 12'h020; Rd = 1'b1;
      @(posedge Clk);
      #1;
      Rd = 1'b0;
      @(negedge Clk);
      check("pre_rst_ramsel", {31'd0, RamSel}, 32'd1);
      #2;
      Reset = 1'b0;
      #1;
      check("async_rst_sels", {30'd0, RamSel, IoSel}, 32'd0);
      check("async_rst_busy", {31'd0, Busy}, 32'd0);
      @(negedge Clk);
      Reset = 1'b1;
      model_rd = 16'h0000;
      @(negedge Clk);
      check("post_rst_rddata", {16'd0, RdData}, 32'd0);
      check("post_rst_busy", {31'd0, Busy}, 32'd0);

      // randomized traffic
      for (int n = 0; n < 150; n++) begin
         if ($urandom_range(0, 9) == 0) illegal();
         else issue(pick_addr(), 1'($urandom), 16'($urandom), $urandom_range(0, 17),
                    16'($urandom), ($urandom_range(0, 3) == 0));
      end

      repeat (5) @(negedge Clk);
      check("queue_drained", exp_q.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched + 1);
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/mu0_mem_router.md
Name: mu0_mem_router

Overview:
- Sequential address-decoding router that sits between the MU0 datapath's memory port and two memory-side responders: main RAM and the memory-mapped I/O block.
- Accepts one processor read or write request at a time and steers it to one target by address.
- Holds a level request/acknowledge handshake with that target.
- Steers returned read data back to the processor.
- Reports completion or a timeout error.

Parameters:
- ADDR_W, 12, address width (MU0 word address).
- DATA_W, 16, data width.
- IO_BASE, 12'hF00, lowest address decoded to the I/O target; addresses below it go to RAM.
- TIMEOUT, 15, maximum WAIT cycles before abort; range 1..255.

Ports:
- Clk  input  1  system clock, rising edge.
- Reset  input  1  asynchronous, active-low reset.
- Address  input  ADDR_W  processor request address.
- WrData  input  DATA_W  processor write data.
- Rd  input  1  processor read request, sampled in IDLE.
- Wr  input  1  processor write request, sampled in IDLE.
- RdData  output  DATA_W  read result; valid from the Done pulse until the next Done.
- Busy  output  1  high while a transaction is in flight.
- Done  output  1  one-cycle completion pulse.
- Err  output  1  one-cycle error pulse; coincides with Done on timeout, or stands alone on an illegal request.
- MemAddr  output  ADDR_W  latched address, shared by both targets.
- MemWrData  output  DATA_W  latched write data, shared by both targets.
- MemWr  output  1  1 = write, 0 = read; qualified by a select.
- RamSel  output  1  RAM request, level.
- IoSel  output  1  I/O request, level.
- RamRdData  input  DATA_W  RAM read data; valid when RamAck is high.
- RamAck  input  1  RAM acknowledge.
- IoRdData  input  DATA_W  I/O read data; valid when IoAck is high.
- IoAck  input  1  I/O acknowledge.

Behaviour:
- Reset (Reset low, asynchronous):
  - State returns to IDLE.
  - RdData, MemAddr, MemWrData and the timeout counter go to 0.
  - Busy, Done, Err, MemWr, RamSel and IoSel go to 0.
  - Reset asserted mid-transaction drops RamSel/IoSel immediately, without waiting for a clock edge.
- All other state changes happen on the rising edge of Clk.
- States: IDLE, WAIT, DONE.
- IDLE:
  - Rd and Wr both high: request ignored, Err pulses for one cycle, stay in IDLE.
  - Exactly one of Rd or Wr high: latch Address, WrData and direction; target = I/O if Address >= IO_BASE, else RAM; assert the selected Sel; Busy goes high; clear the counter; go to WAIT.
- WAIT:
  - The selected Sel is held high.
  - On an edge where the selected Ack is high: drop Sel. If the transaction is a read, capture that target's RdData into RdData. Go to DONE.
  - An Ack from the non-selected target is ignored.
  - If the counter reaches TIMEOUT with no Ack: drop Sel, leave RdData unchanged, set an error flag, go to DONE.
  - Otherwise the counter increments each cycle.
- DONE (one cycle):
  - Done = 1; Err = 1 only if the transaction timed out.
  - Busy stays high in DONE and goes low on return to IDLE.
  - Rd and Wr are not sampled in DONE.
- Latency:
  - Request sampled at edge N; Sel is high during cycle N+1.
  - Ack high at edge N+1 gives Done during cycle N+2. This is the minimum: a 2-cycle read/write.
  - Each extra wait cycle adds one.
- Rd and Wr asserted while Busy are ignored; the processor must hold its request until Done.
- At most one of RamSel and IoSel is high at any time.
- Boundaries:
  - Address IO_BASE-1 decodes to RAM; IO_BASE decodes to I/O.
  - 12'hFFF decodes to I/O with no wrap.
  - Ack arriving on the same edge the counter hits TIMEOUT is treated as success (Ack has priority).

Test Plan:
- Reset low mid-WAIT with RamSel high -> RamSel=0 before the next edge; Busy=0; RdData=16'h0000 after release.
- Read 12'h010; RAM returns 16'hBEEF with Ack one cycle after RamSel -> RamSel for 1 cycle; Done at N+2; RdData=16'hBEEF; IoSel never high.
- Write 16'h1234 to 12'hF00; IoAck after 3 cycles -> IoSel high 4 cycles; MemWr=1; MemWrData=16'h1234; Done pulse; RdData unchanged.
- Decode boundary:
  - Read 12'hEFF -> RamSel.
  - Read 12'hFFF -> IoSel.
  - A stray IoAck during the RAM transaction -> ignored.
- Read 12'hF05 with no IoAck (TIMEOUT=15) -> IoSel high 16 cycles, then Done and Err together; RdData keeps its old value; the next request is accepted normally.
- Error and ignore paths:
  - Rd and Wr both high in IDLE -> Err 1-cycle pulse, no Sel, no Busy.
  - A new Rd pulse during WAIT -> ignored, no second transaction.
